// File: rtl/mul_issue.sv
// Single-issue wrapper around a combinational 32x32 multiplier: operands are registered,
// held for SETTLE cycles, then the selected product half is captured and handed off.

module mul32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    output logic [31:0] lo,
    output logic [31:0] hi
);
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    // Sign-extending to 64 bits makes the truncated unsigned product equal the signed one.
    always_comb begin
        ext_a = {{32{mode & a[31]}}, a};
        ext_b = {{32{mode & b[31]}}, b};
        prod  = ext_a * ext_b;
    end

    assign lo = prod[31:0];
    assign hi = prod[63:32];
endmodule

module mul_issue #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b10;
    localparam logic [1:0] OpMulhu  = 2'b11;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [31:0] result_q;
    logic        out_valid_q;

    logic        mul_mode;
    logic [31:0] mul_lo;
    logic [31:0] mul_hi;
    logic [31:0] sel_res;

    assign mul_mode = ~op_q[1];

    mul32 u_mul32 (
        .a    (a_q),
        .b    (b_q),
        .mode (mul_mode),
        .lo   (mul_lo),
        .hi   (mul_hi)
    );

    // MULHSU runs unsigned and removes the 2^32*b term a negative rs1 would contribute.
    always_comb begin
        sel_res = mul_lo;
        unique case (op_q)
            OpMul:            sel_res = mul_lo;
            OpMulh, OpMulhu:  sel_res = mul_hi;
            OpMulhsu:         sel_res = mul_hi - (a_q[31] ? b_q : 32'd0);
            default:          sel_res = mul_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 2'd0;
            result_q    <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cnt_q   <= 4'(SETTLE);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd1) begin
                        result_q    <= sel_res;
                        out_valid_q <= 1'b1;
                        cnt_q       <= 4'd0;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_mul_issue.sv
// Scoreboard bench for mul_issue: three instances (SETTLE 2, 1, 4) share clock and reset.

module tb_mul_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [1:0]  op        [3];
    logic [31:0] a         [3];
    logic [31:0] b         [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] result    [3];
    logic        busy      [3];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mul_issue #(.SETTLE(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op[0]),
        .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(result[0]), .busy(busy[0])
    );
    mul_issue #(.SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op[1]),
        .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(result[1]), .busy(busy[1])
    );
    mul_issue #(.SETTLE(4)) u_dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .op(op[2]),
        .a(a[2]), .b(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .result(result[2]), .busy(busy[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00:   begin p = sx * sy; return p[31:0];  end
            2'b01:   begin p = sx * sy; return p[63:32]; end
            2'b10:   begin p = sx * uy; return p[63:32]; end
            default: begin p = ux * uy; return p[63:32]; end
        endcase
    endfunction

    // Present one request for a single edge, then scramble the operand inputs.
    task automatic issue(input int d, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        in_valid[d] = 1'b1;
        op[d] = o;
        a[d] = x;
        b[d] = y;
        tick();
        in_valid[d] = 1'b0;
        a[d] = $urandom;
        b[d] = $urandom;
        op[d] = 2'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy[0]); end
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready[0]); end
        n_cmp++; if (result[0] !== 32'd0) begin n_bad++; $display("FAIL reset_result got=%h want=0", result[0]); end
    endtask

    task automatic test_basic();
        logic [31:0] e;
        out_ready[0] = 1'b1;
        issue(0, 2'b00, 32'd292, 32'd6785);
        exp_q.push_back(32'h001E_3B24);
        n_cmp++; if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL basic_accept busy=%b in_ready=%b want 1/0", busy[0], in_ready[0]); end
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL basic_early0 got=%b want=0", out_valid[0]); end
        tick();
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_bad++; $display("FAIL basic_early1 got=%b want=0", out_valid[0]); end
        tick();
        n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b want=1", out_valid[0]); end
        e = exp_q.pop_front();
        n_cmp++; if (result[0] !== e) begin n_bad++; $display("FAIL basic_result got=%h want=%h", result[0], e); end
        tick();
        n_cmp++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL basic_one_cycle out_valid=%b in_ready=%b want 0/1", out_valid[0], in_ready[0]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops  [4];
        logic [31:0] exps [4];
        logic [31:0] e;
        int lat;
        bit saw_ready;
        ops[0] = 2'b00; exps[0] = 32'hFFFF_FFFE;
        ops[1] = 2'b01; exps[1] = 32'hFFFF_FFFF;
        ops[2] = 2'b11; exps[2] = 32'h0000_0001;
        ops[3] = 2'b10; exps[3] = 32'hFFFF_FFFF;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(0, ops[i], 32'hFFFF_FFFF, 32'd2);
            exp_q.push_back(exps[i]);
            lat = 0;
            saw_ready = 1'b0;
            while (out_valid[0] !== 1'b1 && lat < 50) begin
                if (in_ready[0] !== 1'b0) saw_ready = 1'b1;
                tick();
                lat++;
            end
            if (in_ready[0] !== 1'b0) saw_ready = 1'b1;
            n_cmp++; if (saw_ready) begin n_bad++; $display("FAIL b2b_in_ready op=%0d got=1 want=0", i); end
            n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL b2b_latency op=%0d got=%0d want=2", i, lat); end
            e = exp_q.pop_front();
            n_cmp++; if (result[0] !== e) begin n_bad++; $display("FAIL b2b_result op=%0d got=%h want=%h", i, result[0], e); end
            tick();
        end
    endtask

    task automatic test_mulhsu_pos();
        logic [31:0] e;
        int n;
        out_ready[0] = 1'b1;
        issue(0, 2'b10, 32'd2, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0001);
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 50) begin tick(); n++; end
        e = exp_q.pop_front();
        n_cmp++; if (out_valid[0] !== 1'b1 || result[0] !== e) begin n_bad++; $display("FAIL mulhsu_pos valid=%b got=%h want=%h", out_valid[0], result[0], e); end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] e;
        int n;
        bit extra;
        out_ready[0] = 1'b0;
        issue(0, 2'b00, 32'd7, 32'd9);
        exp_q.push_back(32'd63);
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 50) begin tick(); n++; end
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_valid[0] !== 1'b1 || result[0] !== e) begin n_bad++; $display("FAIL stall_hold cyc=%0d valid=%b got=%h want=%h", k, out_valid[0], result[0], e); end
            if (k == 0) begin
                in_valid[0] = 1'b1; op[0] = 2'b00; a[0] = 32'd1000; b[0] = 32'd1000;
            end
            tick();
            in_valid[0] = 1'b0;
        end
        n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL stall_still_done got=%b want=1", out_valid[0]); end
        out_ready[0] = 1'b1;
        tick();
        n_cmp++; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL stall_release valid=%b busy=%b in_ready=%b want 0/0/1", out_valid[0], busy[0], in_ready[0]); end
        extra = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) extra = 1'b1;
            tick();
        end
        n_cmp++; if (extra) begin n_bad++; $display("FAIL stall_no_queue got=1 want=0"); end
        n_cmp++; if (result[0] !== e) begin n_bad++; $display("FAIL stall_retain got=%h want=%h", result[0], e); end
    endtask

    task automatic test_reset_wait();
        bit extra;
        out_ready[0] = 1'b1;
        issue(0, 2'b00, 32'd5, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin n_bad++; $display("FAIL rstwait_state valid=%b busy=%b want 0/0", out_valid[0], busy[0]); end
        n_cmp++; if (result[0] !== 32'd0 || in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rstwait_clear result=%h in_ready=%b want 0/1", result[0], in_ready[0]); end
        extra = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid[0] !== 1'b0) extra = 1'b1;
        end
        n_cmp++; if (extra) begin n_bad++; $display("FAIL rstwait_pulse got=1 want=0"); end
    endtask

    task automatic test_random(input int d, input int count);
        logic [1:0]  o;
        logic [31:0] x, y, e;
        int n;
        for (int i = 0; i < count; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       x = 32'h8000_0000;
                1:       x = 32'hFFFF_FFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       y = 32'h8000_0000;
                1:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            issue(d, o, x, y);
            exp_q.push_back(ref_mul(o, x, y));
            n = 0;
            while (out_valid[d] !== 1'b1 && n < 50) begin
                out_ready[d] = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            out_ready[d] = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (out_valid[d] !== 1'b1 || result[d] !== e) begin
                n_bad++;
                $display("FAIL random dut=%0d op=%0d a=%h b=%h valid=%b got=%h want=%h",
                         d, o, x, y, out_valid[d], result[d], e);
            end
            repeat ($urandom_range(0, 2)) tick();
            out_ready[d] = 1'b1;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; op[i] = 2'd0; a[i] = 32'd0; b[i] = 32'd0; out_ready[i] = 1'b1;
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_mulhsu_pos();
        test_stall();
        test_reset_wait();
        test_random(1, 500);
        test_random(2, 500);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
